conv1_window_gen: RTL and testbench

- Producer side of the conv1 window interface. It turns a raster-order pixel stream (one unsigned pixel per accepted cycle, one MNIST frame) into 25 parallel 5x5 window taps plus a valid strobe.
- The taps drive data_out_0..data_out_24 and valid_out_buf of the conv1 convolution-sum stage.
- It buffers FILTER_SIZE-1 full image rows plus FILTER_SIZE pixels.
- It asserts valid_out_buf only for fully-populated (valid-padding) window positions.

---
 rtl/cnn_pkg.sv | 9 +
 rtl/conv1_pos_counter.sv | 39 +++
 rtl/conv1_window_gen.sv | 97 +++++++++
 tb/tb_conv1_window_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared conv1 constants and pixel type
package cnn_pkg;
  localparam int CONV1_FILTER_SIZE = 5;
  localparam int CONV1_TAPS = 25;
  localparam int CONV1_IMG_W = 28;
  localparam int CONV1_IMG_H = 28;
  localparam int CONV1_DATA_BITS = 8;
  typedef logic [CONV1_DATA_BITS-1:0] pixel_t;
endpackage

// File: rtl/conv1_pos_counter.sv
// conv1_pos_counter: raster row/col position of the next accepted pixel
module conv1_pos_counter
  import cnn_pkg::*;
#(
  parameter int WIDTH = CONV1_IMG_W,
  parameter int HEIGHT = CONV1_IMG_H,
  parameter int FS = CONV1_FILTER_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  output logic [$clog2(HEIGHT)-1:0] row_o,
  output logic [$clog2(WIDTH)-1:0]  col_o,
  output logic                      window_ok_o
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic col_end, row_end;
  always_comb begin
    col_end = col_q == CW'(WIDTH - 1);
    row_end = row_q == RW'(HEIGHT - 1);
    col_d = !en_i ? col_q : col_end ? '0 : col_q + 1'b1;
    row_d = !(en_i && col_end) ? row_q : row_end ? '0 : row_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
  assign row_o = row_q;
  assign col_o = col_q;
  assign window_ok_o = row_q >= RW'(FS - 1) && col_q >= CW'(FS - 1);
endmodule

// File: rtl/conv1_window_gen.sv
// conv1_window_gen: raster pixel stream to 25 parallel 5x5 window taps
module conv1_window_gen
  import cnn_pkg::*;
#(
  parameter int WIDTH = CONV1_IMG_W,
  parameter int HEIGHT = CONV1_IMG_H,
  parameter int DATA_BITS = CONV1_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] data_out_0,
  output logic [DATA_BITS-1:0] data_out_1,
  output logic [DATA_BITS-1:0] data_out_2,
  output logic [DATA_BITS-1:0] data_out_3,
  output logic [DATA_BITS-1:0] data_out_4,
  output logic [DATA_BITS-1:0] data_out_5,
  output logic [DATA_BITS-1:0] data_out_6,
  output logic [DATA_BITS-1:0] data_out_7,
  output logic [DATA_BITS-1:0] data_out_8,
  output logic [DATA_BITS-1:0] data_out_9,
  output logic [DATA_BITS-1:0] data_out_10,
  output logic [DATA_BITS-1:0] data_out_11,
  output logic [DATA_BITS-1:0] data_out_12,
  output logic [DATA_BITS-1:0] data_out_13,
  output logic [DATA_BITS-1:0] data_out_14,
  output logic [DATA_BITS-1:0] data_out_15,
  output logic [DATA_BITS-1:0] data_out_16,
  output logic [DATA_BITS-1:0] data_out_17,
  output logic [DATA_BITS-1:0] data_out_18,
  output logic [DATA_BITS-1:0] data_out_19,
  output logic [DATA_BITS-1:0] data_out_20,
  output logic [DATA_BITS-1:0] data_out_21,
  output logic [DATA_BITS-1:0] data_out_22,
  output logic [DATA_BITS-1:0] data_out_23,
  output logic [DATA_BITS-1:0] data_out_24,
  output logic                 valid_out_buf
);
  localparam int FS = CONV1_FILTER_SIZE;
  localparam int L = (FS - 1) * WIDTH + FS;
  logic [DATA_BITS-1:0] buf_q [L];
  logic [DATA_BITS-1:0] taps [CONV1_TAPS];
  logic valid_q, window_ok;
  conv1_pos_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FS(FS)) u_pos (
    .clk(clk),
    .rst(rst),
    .en_i(valid_in),
    .row_o(),
    .col_o(),
    .window_ok_o(window_ok)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) buf_q[i] <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_in) begin
        buf_q[0] <= data_in;
        for (int i = 1; i < L; i++) buf_q[i] <= buf_q[i-1];
      end
      valid_q <= valid_in && window_ok;
    end
  end
  // buf_q[0] is newest, so the bottom-right tap reads offset 0
  for (genvar r = 0; r < FS; r++) begin : g_row
    for (genvar c = 0; c < FS; c++) begin : g_col
      assign taps[r*FS+c] = buf_q[(FS-1-r)*WIDTH + (FS-1-c)];
    end
  end
  assign data_out_0 = taps[0];
  assign data_out_1 = taps[1];
  assign data_out_2 = taps[2];
  assign data_out_3 = taps[3];
  assign data_out_4 = taps[4];
  assign data_out_5 = taps[5];
  assign data_out_6 = taps[6];
  assign data_out_7 = taps[7];
  assign data_out_8 = taps[8];
  assign data_out_9 = taps[9];
  assign data_out_10 = taps[10];
  assign data_out_11 = taps[11];
  assign data_out_12 = taps[12];
  assign data_out_13 = taps[13];
  assign data_out_14 = taps[14];
  assign data_out_15 = taps[15];
  assign data_out_16 = taps[16];
  assign data_out_17 = taps[17];
  assign data_out_18 = taps[18];
  assign data_out_19 = taps[19];
  assign data_out_20 = taps[20];
  assign data_out_21 = taps[21];
  assign data_out_22 = taps[22];
  assign data_out_23 = taps[23];
  assign data_out_24 = taps[24];
  assign valid_out_buf = valid_q;
endmodule

// File: tb/tb_conv1_window_gen.sv
// tb_conv1_window_gen: directed vectors and frame sequences for conv1_window_gen
module tb_conv1_window_gen;
  logic clk = 1'b0;
  logic rst, valid_in;
  logic [7:0] data_in;
  logic [7:0] dout [25];
  logic valid_out_buf;
  int passed = 0, total = 0;
  typedef struct {
    int idx;
    int v;
    int t0, t4, t12, t20, t24;
  } vec_t;
  vec_t vt [9];
  conv1_window_gen dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .data_out_0(dout[0]), .data_out_1(dout[1]), .data_out_2(dout[2]),
    .data_out_3(dout[3]), .data_out_4(dout[4]), .data_out_5(dout[5]),
    .data_out_6(dout[6]), .data_out_7(dout[7]), .data_out_8(dout[8]),
    .data_out_9(dout[9]), .data_out_10(dout[10]), .data_out_11(dout[11]),
    .data_out_12(dout[12]), .data_out_13(dout[13]), .data_out_14(dout[14]),
    .data_out_15(dout[15]), .data_out_16(dout[16]), .data_out_17(dout[17]),
    .data_out_18(dout[18]), .data_out_19(dout[19]), .data_out_20(dout[20]),
    .data_out_21(dout[21]), .data_out_22(dout[22]), .data_out_23(dout[23]),
    .data_out_24(dout[24]), .valid_out_buf(valid_out_buf)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic step(logic v, logic [7:0] d);
    valid_in = v;
    data_in = d;
    @(posedge clk);
    #1;
  endtask
  // window completed by raster pixel p: tap (r,c) holds pixel (R-4+r, C-4+c)
  function automatic int win_errs(int p);
    int rr = p / 28, cc = p % 28, e = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (dout[r*5+c] !== 8'((rr - 4 + r) * 28 + (cc - 4 + c))) e++;
    return e;
  endfunction
  function automatic int zero_taps();
    int n = 0;
    for (int t = 0; t < 25; t++) if (dout[t] === 8'h00) n++;
    return n;
  endfunction
  function automatic int ff_taps();
    int n = 0;
    for (int t = 0; t < 25; t++) if (dout[t] === 8'hFF) n++;
    return n;
  endfunction
  function automatic int exp_valid(int p);
    return (p / 28 >= 4 && p % 28 >= 4) ? 1 : 0;
  endfunction
  initial begin
    int pulses, bad, badv, first;
    vt[0] = '{115, 0, -1, -1, -1, -1, -1};
    vt[1] = '{116, 1, 0, 4, 58, 112, 116};
    vt[2] = '{140, 0, -1, -1, -1, -1, -1};
    vt[3] = '{141, 0, -1, -1, -1, -1, -1};
    vt[4] = '{142, 0, -1, -1, -1, -1, -1};
    vt[5] = '{143, 0, -1, -1, -1, -1, -1};
    vt[6] = '{144, 1, 28, 32, 86, 140, 144};
    vt[7] = '{145, 1, 29, 33, 87, 141, 145};
    vt[8] = '{783, 1, 155, 159, 213, 11, 15};
    rst = 1'b1;
    valid_in = 1'b0;
    data_in = '0;
    step(0, 0);
    step(0, 0);
    rst = 1'b0;
    chk("reset_taps_zero", zero_taps(), 25);
    chk("reset_valid", int'(valid_out_buf), 0);
    // frame A: continuous, pixel = raster index mod 256
    pulses = 0; bad = 0; badv = 0;
    for (int p = 0; p < 784; p++) begin
      step(1, 8'(p));
      if (int'(valid_out_buf) != exp_valid(p)) badv++;
      if (valid_out_buf === 1'b1) begin
        pulses++;
        bad += win_errs(p);
      end
      foreach (vt[i]) if (vt[i].idx == p) begin
        chk($sformatf("vec%0d_valid", p), int'(valid_out_buf), vt[i].v);
        if (vt[i].v == 1) begin
          chk($sformatf("vec%0d_tap0", p), int'(dout[0]), vt[i].t0);
          chk($sformatf("vec%0d_tap4", p), int'(dout[4]), vt[i].t4);
          chk($sformatf("vec%0d_tap12", p), int'(dout[12]), vt[i].t12);
          chk($sformatf("vec%0d_tap20", p), int'(dout[20]), vt[i].t20);
          chk($sformatf("vec%0d_tap24", p), int'(dout[24]), vt[i].t24);
        end
      end
    end
    chk("frameA_pulses", pulses, 576);
    chk("frameA_tap_errs", bad, 0);
    chk("frameA_valid_errs", badv, 0);
    // frame B back-to-back, all 0xFF
    pulses = 0; first = -1; bad = 0;
    for (int p = 0; p < 784; p++) begin
      step(1, 8'hFF);
      if (valid_out_buf === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = p;
          bad = 25 - ff_taps();
        end
      end
    end
    chk("frameB_first_pulse", first, 116);
    chk("frameB_first_taps_ff", bad, 0);
    chk("frameB_pulses", pulses, 576);
    step(0, 8'h00);
    chk("idle_after_last_valid", int'(valid_out_buf), 0);
    chk("idle_taps_hold", int'(dout[24]), 255);
    // frame C: valid_in toggles 1-0-1-0
    pulses = 0; bad = 0; badv = 0;
    for (int p = 0; p < 784; p++) begin
      step(1, 8'(p));
      if (int'(valid_out_buf) != exp_valid(p)) badv++;
      if (valid_out_buf === 1'b1) begin
        pulses++;
        bad += win_errs(p);
      end
      step(0, 8'hAA);
      if (valid_out_buf !== 1'b0) badv++;
      if (dout[24] !== 8'(p)) bad++;
    end
    chk("frameC_pulses", pulses, 576);
    chk("frameC_tap_errs", bad, 0);
    chk("frameC_valid_errs", badv, 0);
    // frame D: reset together with pixel 300
    for (int p = 0; p < 300; p++) step(1, 8'(p));
    rst = 1'b1;
    step(1, 8'(300));
    rst = 1'b0;
    chk("midreset_taps_zero", zero_taps(), 25);
    chk("midreset_valid", int'(valid_out_buf), 0);
    pulses = 0; first = -1; bad = 0; badv = 0;
    for (int p = 0; p < 784; p++) begin
      step(1, 8'(p));
      if (int'(valid_out_buf) != exp_valid(p)) badv++;
      if (valid_out_buf === 1'b1) begin
        pulses++;
        bad += win_errs(p);
        if (first < 0) first = p;
      end
    end
    chk("frameE_first_pulse", first, 116);
    chk("frameE_pulses", pulses, 576);
    chk("frameE_tap_errs", bad, 0);
    chk("frameE_valid_errs", badv, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
